// File: rtl/reg_file_if.sv
// Write-back and register read bus between the pipeline and reg_file.
// The master side drives write-back and read addresses; the slave side returns data.
interface reg_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic [DATA_WIDTH-1:0] sp_data;
    logic [DATA_WIDTH-1:0] ih_data;
    logic [DATA_WIDTH-1:0] t_data;
    logic [7:0]            wr_count;

    modport master (
        output wb_en, wb_addr, wb_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, sp_data, ih_data, t_data, wr_count
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, sp_data, ih_data, t_data, wr_count
    );
endinterface

// File: rtl/reg_file.sv
// Twelve-entry register file (R0-R7, SP, IH, T, RA) with two combinational read ports,
// dedicated SP/IH/T outputs and a committed-write counter. Define WB_BYPASS_EN to forward write-back data.
module reg_file #(
    parameter int                  DATA_WIDTH = 16,
    parameter int                  ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] SP_RESET = 16'hBF00
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_if.slave    bus
);
    localparam int NUM_REGS = 12;
    localparam int SP_IDX   = 8;
    localparam int IH_IDX   = 9;
    localparam int T_IDX    = 10;
    localparam int RA_IDX   = 11;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [7:0]            r_wr_count;
    logic                  w_wr_commit;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    // Unmapped addresses read as zero.
    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_WIDTH'(i)) v = r_regs[i];
        end
        return v;
    endfunction

`ifdef WB_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] f_fwd(input logic [ADDR_WIDTH-1:0] addr,
                                                   input logic [DATA_WIDTH-1:0] stored);
        if (!rst && w_wr_commit && (bus.wb_addr == addr)) return bus.wb_data;
        return stored;
    endfunction
`endif

    assign w_wr_commit = bus.wb_en && (bus.wb_addr <= ADDR_WIDTH'(RA_IDX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wb_addr == ADDR_WIDTH'(i)) r_regs[i] <= bus.wb_data;
            end
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    always_comb begin
        w_rd_a = f_read(bus.rd_addr_a);
        w_rd_b = f_read(bus.rd_addr_b);
`ifdef WB_BYPASS_EN
        // Forwarding is gated by the mapped-address commit, so unmapped reads stay zero.
        bus.rd_data_a = f_fwd(bus.rd_addr_a, w_rd_a);
        bus.rd_data_b = f_fwd(bus.rd_addr_b, w_rd_b);
        bus.sp_data   = f_fwd(ADDR_WIDTH'(SP_IDX), r_regs[SP_IDX]);
        bus.ih_data   = f_fwd(ADDR_WIDTH'(IH_IDX), r_regs[IH_IDX]);
        bus.t_data    = f_fwd(ADDR_WIDTH'(T_IDX),  r_regs[T_IDX]);
`else
        bus.rd_data_a = w_rd_a;
        bus.rd_data_b = w_rd_b;
        bus.sp_data   = r_regs[SP_IDX];
        bus.ih_data   = r_regs[IH_IDX];
        bus.t_data    = r_regs[T_IDX];
`endif
    end

    assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, writes to each class of register, unmapped
// accesses, counter wrap and reset/write collision.
module tb_reg_file;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    reg_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    reg_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SP_RESET(16'hBF00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.wb_en = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.rd_addr_a = 4'd0;
        bus.rd_addr_b = 4'd11;
        #2;
        check("rst_sp", bus.sp_data, 16'hBF00);
        check("rst_ih", bus.ih_data, 16'h0000);
        check("rst_t", bus.t_data, 16'h0000);
        check("rst_r0", bus.rd_data_a, 16'h0000);
        check("rst_ra", bus.rd_data_b, 16'h0000);
        check("rst_cnt", {8'h00, bus.wr_count}, 16'h0000);

        @(negedge clk);
        rst = 1'b0;

        // R3 write with same-cycle read
        @(negedge clk);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 16'h1234; bus.rd_addr_a = 4'd3;
        #1;
`ifdef WB_BYPASS_EN
        check("r3_pre_edge", bus.rd_data_a, 16'h1234);
`else
        check("r3_pre_edge", bus.rd_data_a, 16'h0000);
`endif
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
        check("r3_post_edge", bus.rd_data_a, 16'h1234);
        check("cnt_1", {8'h00, bus.wr_count}, 16'h0001);

        do_write(4'd9, 16'h00A5);
        bus.rd_addr_b = 4'd9;
        #1;
        check("ih_port", bus.ih_data, 16'h00A5);
        check("ih_rd_b", bus.rd_data_b, 16'h00A5);

        do_write(4'd10, 16'h5A5A);
        bus.rd_addr_a = 4'd10;
        #1;
        check("t_port", bus.t_data, 16'h5A5A);
        check("t_rd_a", bus.rd_data_a, 16'h5A5A);

        do_write(4'd11, 16'hC3C3);
        bus.rd_addr_a = 4'd11;
        #1;
        check("ra_rd_a", bus.rd_data_a, 16'hC3C3);
        check("cnt_4", {8'h00, bus.wr_count}, 16'h0004);

        // unmapped write is dropped
        do_write(4'd13, 16'hFFFF);
        bus.rd_addr_a = 4'd13; bus.rd_addr_b = 4'd3;
        #1;
        check("unm_rd", bus.rd_data_a, 16'h0000);
        check("unm_r3", bus.rd_data_b, 16'h1234);
        check("unm_ih", bus.ih_data, 16'h00A5);
        check("unm_sp", bus.sp_data, 16'hBF00);
        check("unm_cnt", {8'h00, bus.wr_count}, 16'h0004);

        @(negedge clk);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd13; bus.wb_data = 16'hFFFF; bus.rd_addr_a = 4'd13;
        #1;
        check("unm_no_fwd", bus.rd_data_a, 16'h0000);
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;

        do_write(4'd8, 16'h7FF0);
        bus.rd_addr_a = 4'd8; bus.rd_addr_b = 4'd8;
        #1;
        check("sp_rd_a", bus.rd_data_a, 16'h7FF0);
        check("sp_rd_b", bus.rd_data_b, 16'h7FF0);
        check("sp_port", bus.sp_data, 16'h7FF0);
        check("cnt_5", {8'h00, bus.wr_count}, 16'h0005);

        // wb_en low: address/data ignored
        @(negedge clk);
        bus.wb_en = 1'b0; bus.wb_addr = 4'd3; bus.wb_data = 16'hDEAD; bus.rd_addr_a = 4'd3;
        @(posedge clk);
        #1;
        check("idle_r3", bus.rd_data_a, 16'h1234);
        check("idle_cnt", {8'h00, bus.wr_count}, 16'h0005);

        for (int i = 0; i < 8; i++) do_write(4'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr_a = 4'(i);
            bus.rd_addr_b = 4'(7 - i);
            #1;
            check("gpr_a", bus.rd_data_a, 16'h1000 + 16'(i));
            check("gpr_b", bus.rd_data_b, 16'h1000 + 16'(7 - i));
        end
        check("cnt_13", {8'h00, bus.wr_count}, 16'h000D);

        // asynchronous reset pulse between edges
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd11;
        #1;
        check("arst_sp", bus.sp_data, 16'hBF00);
        check("arst_ih", bus.ih_data, 16'h0000);
        check("arst_t", bus.t_data, 16'h0000);
        check("arst_r5", bus.rd_data_a, 16'h0000);
        check("arst_ra", bus.rd_data_b, 16'h0000);
        check("arst_cnt", {8'h00, bus.wr_count}, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 255; i++) do_write(4'd5, 16'(i));
        check("cnt_255", {8'h00, bus.wr_count}, 16'h00FF);
        do_write(4'd5, 16'hABCD);
        bus.rd_addr_a = 4'd5;
        #1;
        check("cnt_wrap", {8'h00, bus.wr_count}, 16'h0000);
        check("wrap_r5", bus.rd_data_a, 16'hABCD);

        // reset asserted on the write edge wins
        @(negedge clk);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd1; bus.wb_data = 16'h5555; bus.rd_addr_a = 4'd1;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("coll_r1", bus.rd_data_a, 16'h0000);
        check("coll_cnt", {8'h00, bus.wr_count}, 16'h0000);
        check("coll_sp", bus.sp_data, 16'hBF00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
        check("post_rst_r1", bus.rd_data_a, 16'h5555);
        check("post_rst_cnt", {8'h00, bus.wr_count}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
